// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus sequencers (reader and writer).
package rtc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] CMD_LATCH    = 8'hF1;
  localparam logic [DATA_W-1:0] CMD_TRANSFER = 8'hF0;

  typedef enum logic [2:0] {
    INICIO    = 3'd0,
    LATCH     = 3'd1,
    LEER      = 3'd2,
    SIGUIENTE = 3'd3,
    FINAL     = 3'd4
  } estado_t;

endpackage

// File: rtl/rtc_lectura.sv
// RTC read sequencer: latch command, then a burst of register reads through the
// shared bus driver, each returned byte qualified by a one-cycle strobe.
module rtc_lectura #(
  parameter logic [7:0] CMD_LATCH = rtc_pkg::CMD_LATCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] dir,
  input  logic [3:0] cantidad,
  input  logic       fin,
  input  logic [7:0] dato_in,
  output logic [7:0] dir_out,
  output logic [7:0] data_out,
  output logic       escribe,
  output logic       lee,
  output logic       activa,
  output logic       finalizado,
  output logic [7:0] dato_leido,
  output logic       valido,
  output logic [3:0] indice
);

  import rtc_pkg::*;

  estado_t             state, state_n;
  logic [ADDR_W-1:0]   dir_q, dir_n;
  logic [CNT_W-1:0]    cant_q, cant_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;

  logic [ADDR_W-1:0]   dir_out_n;
  logic [DATA_W-1:0]   data_out_n;
  logic                escribe_n, lee_n, activa_n, finalizado_n, valido_n;
  logic [DATA_W-1:0]   dato_leido_n;
  logic [CNT_W-1:0]    indice_n;

  // Next state, burst bookkeeping and the registered outputs of the state being entered
  always_comb begin
    state_n      = state;
    dir_n        = dir_q;
    cant_n       = cant_q;
    cnt_n        = cnt_q;
    dir_out_n    = '0;
    data_out_n   = '0;
    escribe_n    = 1'b0;
    lee_n        = 1'b0;
    activa_n     = 1'b0;
    finalizado_n = 1'b0;
    valido_n     = 1'b0;
    dato_leido_n = dato_leido;
    indice_n     = indice;

    case (state)
      INICIO: begin
        if (iniciar) begin
          dir_n   = dir;
          cant_n  = cantidad;
          cnt_n   = '0;
          state_n = LATCH;
        end
      end
      LATCH: begin
        if (fin) state_n = (cant_q == '0) ? FINAL : LEER;
      end
      LEER: begin
        if (fin) begin
          valido_n     = 1'b1;
          dato_leido_n = dato_in;
          indice_n     = cnt_q;
          if ((5'({1'b0, cnt_q}) + 5'd1) == 5'({1'b0, cant_q})) begin
            state_n = FINAL;
          end else begin
            cnt_n   = cnt_q + CNT_W'(1);
            state_n = SIGUIENTE;
          end
        end
      end
      SIGUIENTE: state_n = LEER;
      FINAL:     state_n = INICIO;
      default:   state_n = INICIO;
    endcase

    case (state_n)
      LATCH: begin
        escribe_n  = 1'b1;
        activa_n   = 1'b1;
        dir_out_n  = CMD_LATCH;
        data_out_n = CMD_LATCH;
      end
      LEER: begin
        lee_n     = 1'b1;
        activa_n  = 1'b1;
        dir_out_n = dir_q + ADDR_W'(cnt_n);
      end
      SIGUIENTE: begin
        activa_n  = 1'b1;
        dir_out_n = dir_q + ADDR_W'(cnt_n);
      end
      FINAL:   finalizado_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INICIO;
      dir_q      <= '0;
      cant_q     <= '0;
      cnt_q      <= '0;
      dir_out    <= '0;
      data_out   <= '0;
      escribe    <= 1'b0;
      lee        <= 1'b0;
      activa     <= 1'b0;
      finalizado <= 1'b0;
      valido     <= 1'b0;
      dato_leido <= '0;
      indice     <= '0;
    end else begin
      state      <= state_n;
      dir_q      <= dir_n;
      cant_q     <= cant_n;
      cnt_q      <= cnt_n;
      dir_out    <= dir_out_n;
      data_out   <= data_out_n;
      escribe    <= escribe_n;
      lee        <= lee_n;
      activa     <= activa_n;
      finalizado <= finalizado_n;
      valido     <= valido_n;
      dato_leido <= dato_leido_n;
      indice     <= indice_n;
    end
  end

endmodule

// File: tb/tb_rtc_lectura.sv
// Randomized bench for rtc_lectura: a behavioural bus driver plus per-burst
// expectations derived from the read-burst rules.
module tb_rtc_lectura;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [7:0] dir;
  logic [3:0] cantidad;
  logic       fin;
  logic [7:0] dato_in;
  logic [7:0] dir_out, data_out, dato_leido;
  logic       escribe, lee, activa, finalizado, valido;
  logic [3:0] indice;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [16];

  rtc_lectura dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .dir(dir), .cantidad(cantidad),
    .fin(fin), .dato_in(dato_in), .dir_out(dir_out), .data_out(data_out),
    .escribe(escribe), .lee(lee), .activa(activa), .finalizado(finalizado),
    .dato_leido(dato_leido), .valido(valido), .indice(indice)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_esc"}, 32'(escribe), 0);
    chk({tag, "_lee"}, 32'(lee), 0);
    chk({tag, "_act"}, 32'(activa), 0);
    chk({tag, "_fin"}, 32'(finalizado), 0);
    chk({tag, "_val"}, 32'(valido), 0);
    chk({tag, "_dir"}, 32'(dir_out), 0);
    chk({tag, "_dat"}, 32'(data_out), 0);
  endtask

  // One complete burst; called at a negedge with the DUT in INICIO, returns at a negedge in INICIO.
  task automatic burst(input logic [7:0] bd, input logic [3:0] bc, input bit rnd);
    int          w;
    logic [7:0]  addr;
    iniciar  = 1'b1;
    dir      = bd;
    cantidad = bc;
    @(negedge clk);
    iniciar  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    dir      = 8'($urandom);
    cantidad = 4'($urandom);
    chk("latch_esc", 32'(escribe), 1);
    chk("latch_act", 32'(activa), 1);
    chk("latch_lee", 32'(lee), 0);
    chk("latch_dir", 32'(dir_out), 32'h F1);
    chk("latch_dat", 32'(data_out), 32'h F1);
    w = rnd ? $urandom_range(0, 4) : 0;
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      iniciar = 1'($urandom_range(0, 1));
      chk("latch_hold", 32'(escribe), 1);
    end
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    if (bc == 4'd0) begin
      chk("c0_final", 32'(finalizado), 1);
      chk("c0_lee", 32'(lee), 0);
      chk("c0_val", 32'(valido), 0);
      chk("c0_act", 32'(activa), 0);
    end else begin
      for (int i = 0; i < int'(bc); i++) begin
        addr = bd + 8'(i);
        chk("rd_lee", 32'(lee), 1);
        chk("rd_esc", 32'(escribe), 0);
        chk("rd_act", 32'(activa), 1);
        chk("rd_dat", 32'(data_out), 0);
        chk("rd_dir", 32'(dir_out), 32'(addr));
        chk("rd_val", 32'(valido), 0);
        if (i > 0) chk("rd_hold", 32'(dato_leido), 32'(mem[i-1]));
        w = rnd ? $urandom_range(0, 5) : 0;
        for (int k = 0; k < w; k++) begin
          @(negedge clk);
          iniciar = 1'($urandom_range(0, 1));
          dir     = 8'($urandom);
          chk("rd_wait_dir", 32'(dir_out), 32'(addr));
          chk("rd_wait_lee", 32'(lee), 1);
        end
        dato_in = mem[i];
        fin     = 1'b1;
        @(negedge clk);
        fin     = 1'b0;
        dato_in = 8'($urandom);
        chk("cap_val", 32'(valido), 1);
        chk("cap_dato", 32'(dato_leido), 32'(mem[i]));
        chk("cap_idx", 32'(indice), 32'(i));
        chk("cap_lee", 32'(lee), 0);
        if (i == int'(bc) - 1) begin
          chk("last_final", 32'(finalizado), 1);
          chk("last_act", 32'(activa), 0);
        end else begin
          chk("sig_final", 32'(finalizado), 0);
          chk("sig_act", 32'(activa), 1);
          fin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
          @(negedge clk);
          fin = 1'b0;
        end
      end
    end
    iniciar = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    fin     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    iniciar = 1'b0;
    fin     = 1'b0;
    chk_idle("post");
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; dir = '0; cantidad = '0; fin = 1'b0; dato_in = '0;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    chk("rst_dato", 32'(dato_leido), 0);
    chk("rst_idx", 32'(indice), 0);
    reset = 1'b0;
    @(negedge clk);
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    chk_idle("stray_fin_idle");

    // Reset in the middle of a read
    iniciar = 1'b1; dir = 8'h10; cantidad = 4'd3;
    @(negedge clk);
    iniciar = 1'b0;
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    chk("mid_lee", 32'(lee), 1);
    chk("mid_dir", 32'(dir_out), 32'h10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("mid_rst");
    @(negedge clk);
    chk_idle("mid_rst2");

    mem[0] = 8'h45; mem[1] = 8'h30; mem[2] = 8'h12;
    burst(8'h02, 4'd3, 1'b0);
    burst(8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    burst(8'hFE, 4'd3, 1'b0);
    burst(8'h20, 4'd4, 1'b1);
    burst(8'hF5, 4'd15, 1'b1);
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      burst(8'($urandom), 4'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
